// File: rtl/cg_pkg.sv
// Purpose : shared types and helpers for the clock-gating latency controller.
// Latency : n/a (types, constants and an elaboration-time function only).
// Backpr. : n/a.
package cg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cg_state_t;

  // Largest supported gadget latency; keeps the counter at 8 bits or less.
  localparam int CG_MAX_LATENCY = 255;

  // Counter width needed to hold LATENCY-1 down to zero.
  function automatic int cg_cnt_w(input int latency);
    if (latency < 1) begin
      return 1;
    end
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/cg_icg_cell.sv
// Purpose : latch-based integrated clock gate; swap for a library ICG cell.
// Latency : en sampled while clk is low, takes effect on the next clk rising edge.
// Backpr. : none.
// Ports   : clk (free-running clock), en (gate enable), gclk (gated clock).
module cg_icg_cell (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic en_l;

  // Transparent while clk is low, so en_l is stable for the whole high phase
  // and gclk can only rise together with clk.
  always_latch begin
    if (!clk) begin
      en_l <= en;
    end
  end

  assign gclk = clk & en_l;

endmodule

// File: rtl/cg_latency_controller.sv
// Purpose : sequences one LATENCY-cycle masked computation per start/ready handshake
//           and fires GatedClk exactly once to capture the masked output shares.
// Latency : start accepted -> LATENCY RUN cycles -> GatedClk edge -> Synch next cycle.
// Backpr. : start_i is taken only while ready_o=1 (IDLE or DONE); ignored during RUN.
// Ports   : clk, rst (sync, active-high), start_i/ready_o handshake, busy_o,
//           fresh_en_o (advance randomness), GatedClk, Synch.
//           With macro CG_ABORT_EN defined, input abort_i cancels a RUN in progress.
module cg_latency_controller
  import cg_pkg::*;
#(
  parameter int LATENCY      = 13,  // legal 1..CG_MAX_LATENCY
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic clk,
  input  logic rst,
`ifdef CG_ABORT_EN
  input  logic abort_i,
`endif
  input  logic start_i,
  output logic ready_o,
  output logic busy_o,
  output logic fresh_en_o,
  output logic GatedClk,
  output logic Synch
);

  localparam int CNT_W = cg_cnt_w(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  cg_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             gate_en;
  logic             abort_req;
  logic             go;

`ifdef CG_ABORT_EN
  assign abort_req = abort_i;
`else
  assign abort_req = 1'b0;
`endif

  // In legacy mode the controller restarts on its own and start_i is a don't-care.
  assign go = AUTO_RESTART | start_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    gate_en    = 1'b0;
    ready_o    = 1'b0;
    busy_o     = 1'b0;
    fresh_en_o = 1'b0;
    Synch      = 1'b0;

    case (state)
      IDLE: begin
        ready_o = ~AUTO_RESTART;
        if (go) begin
          state_nxt = RUN;
          cnt_nxt   = CNT_LOAD;
        end
      end

      RUN: begin
        busy_o     = 1'b1;
        fresh_en_o = 1'b1;
        if (abort_req) begin
          // Abort wins over completion: no capture edge, no Synch.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          gate_en   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      DONE: begin
        Synch   = 1'b1;
        ready_o = ~AUTO_RESTART;
        if (go) begin
          // Back-to-back: reload straight into RUN, no idle bubble.
          state_nxt = RUN;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // A reset arriving in the last RUN cycle must cancel the pending capture edge.
    if (rst) begin
      gate_en = 1'b0;
    end
  end

  cg_icg_cell u_icg (
    .clk  (clk),
    .en   (gate_en),
    .gclk (GatedClk)
  );

endmodule

// File: tb/tb_cg_latency_controller.sv
module tb_cg_latency_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, LATENCY=13
  logic rst_m = 1'b1, start_m = 1'b0;
  logic rdy_m, busy_m, fresh_m, gclk_m, synch_m;
  // LATENCY=1 instance
  logic rst_o = 1'b1, start_o = 1'b0;
  logic rdy_o, busy_o, fresh_o, gclk_o, synch_o;
  // AUTO_RESTART=1 instance
  logic rst_a = 1'b1, start_a = 1'b0;
  logic rdy_a, busy_a, fresh_a, gclk_a, synch_a;
`ifdef CG_ABORT_EN
  logic abort_m = 1'b0, abort_o = 1'b0, abort_a = 1'b0;
`endif

  cg_latency_controller #(.LATENCY(13), .AUTO_RESTART(1'b0)) dut_m (
    .clk(clk), .rst(rst_m),
`ifdef CG_ABORT_EN
    .abort_i(abort_m),
`endif
    .start_i(start_m), .ready_o(rdy_m), .busy_o(busy_m), .fresh_en_o(fresh_m),
    .GatedClk(gclk_m), .Synch(synch_m));

  cg_latency_controller #(.LATENCY(1), .AUTO_RESTART(1'b0)) dut_o (
    .clk(clk), .rst(rst_o),
`ifdef CG_ABORT_EN
    .abort_i(abort_o),
`endif
    .start_i(start_o), .ready_o(rdy_o), .busy_o(busy_o), .fresh_en_o(fresh_o),
    .GatedClk(gclk_o), .Synch(synch_o));

  cg_latency_controller #(.LATENCY(13), .AUTO_RESTART(1'b1)) dut_a (
    .clk(clk), .rst(rst_a),
`ifdef CG_ABORT_EN
    .abort_i(abort_a),
`endif
    .start_i(start_a), .ready_o(rdy_a), .busy_o(busy_a), .fresh_en_o(fresh_a),
    .GatedClk(gclk_a), .Synch(synch_a));

  // Gated clock edge counters (monotonic; tests take snapshots)
  int gedge_m = 0, gedge_o = 0, gedge_a = 0;
  always @(posedge gclk_m) gedge_m <= gedge_m + 1;
  always @(posedge gclk_o) gedge_o <= gedge_o + 1;
  always @(posedge gclk_a) gedge_a <= gedge_a + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge: outputs of the new cycle are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst;
    logic start;
    logic rdy;
    logic busy;
    logic fresh;
    logic synch;
    logic gclk;   // GatedClk high just after cycle start = edge ended previous cycle
  } vec_t;

  localparam int NV = 110;
  vec_t tv[NV];

  int   base;
  logic b, s;

  initial begin
    // Cycle-indexed table for the LATENCY=13 instance.
    //  0..21  : reset 2 cycles, start at 5 -> RUN 6..18, Synch 19
    //  22..66 : start held 22..63 -> RUN 23..35/37..49/51..63, DONE 36/50/64
    //  67..90 : start at 67, stray start at 70, rst at 74 -> IDLE 75, nothing after
    //  91..109: start at 91, stray start at 98 -> RUN 92..104, single Synch 105
    for (int c = 0; c < NV; c++) begin
      b = (c >= 6 && c <= 18) || (c >= 23 && c <= 35) || (c >= 37 && c <= 49) ||
          (c >= 51 && c <= 63) || (c >= 68 && c <= 74) || (c >= 92 && c <= 104);
      s = (c == 19) || (c == 36) || (c == 50) || (c == 64) || (c == 105);
      tv[c].rst   = (c < 2) || (c == 74);
      tv[c].start = (c == 5) || (c >= 22 && c <= 63) || (c == 67) || (c == 70) ||
                    (c == 91) || (c == 98);
      tv[c].rdy   = ~b;
      tv[c].busy  = b;
      tv[c].fresh = b;
      tv[c].synch = s;
      tv[c].gclk  = s;
    end

    base = 0;
    for (int c = 0; c < NV; c++) begin
      tick();
      if (c == 2) base = gedge_m;
      check($sformatf("c%0d ready", c), 32'(rdy_m),   32'(tv[c].rdy));
      check($sformatf("c%0d busy", c),  32'(busy_m),  32'(tv[c].busy));
      check($sformatf("c%0d fresh", c), 32'(fresh_m), 32'(tv[c].fresh));
      check($sformatf("c%0d synch", c), 32'(synch_m), 32'(tv[c].synch));
      check($sformatf("c%0d gclk", c),  32'(gclk_m),  32'(tv[c].gclk));
      rst_m   = tv[c].rst;
      start_m = tv[c].start;
    end
    check("main gclk edge total", 32'(gedge_m - base), 32'd5);

`ifdef CG_ABORT_EN
    // Abort on the last RUN cycle (count==0): no edge, no Synch, IDLE next.
    base    = gedge_m;
    start_m = 1'b1;
    tick();                       // RUN cycle 1
    start_m = 1'b0;
    repeat (12) tick();           // RUN cycle 13
    check("abort run13 busy", 32'(busy_m), 32'd1);
    abort_m = 1'b1;
    tick();
    abort_m = 1'b0;
    check("abort next ready", 32'(rdy_m),   32'd1);
    check("abort next busy",  32'(busy_m),  32'd0);
    check("abort next synch", 32'(synch_m), 32'd0);
    check("abort next gclk",  32'(gclk_m),  32'd0);
    tick();
    check("abort later synch", 32'(synch_m), 32'd0);
    check("abort edge count",  32'(gedge_m - base), 32'd0);
    // A fresh start then completes normally.
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    repeat (12) tick();
    check("post-abort run13 busy", 32'(busy_m), 32'd1);
    tick();
    check("post-abort synch", 32'(synch_m), 32'd1);
    check("post-abort gclk",  32'(gclk_m),  32'd1);
    check("post-abort edge count", 32'(gedge_m - base), 32'd1);
`endif

    // LATENCY=1: start in cycle k -> busy and gate in k+1, Synch k+2.
    tick();
    rst_o = 1'b0;
    tick();
    base = gedge_o;
    check("l1 idle ready", 32'(rdy_o),  32'd1);
    check("l1 idle busy",  32'(busy_o), 32'd0);
    start_o = 1'b1;
    tick();
    start_o = 1'b0;
    check("l1 run busy",  32'(busy_o),  32'd1);
    check("l1 run fresh", 32'(fresh_o), 32'd1);
    check("l1 run ready", 32'(rdy_o),   32'd0);
    check("l1 run gclk",  32'(gclk_o),  32'd0);
    tick();
    check("l1 done synch", 32'(synch_o), 32'd1);
    check("l1 done gclk",  32'(gclk_o),  32'd1);
    check("l1 done busy",  32'(busy_o),  32'd0);
    check("l1 done ready", 32'(rdy_o),   32'd1);
    tick();
    check("l1 idle2 synch", 32'(synch_o), 32'd0);
    check("l1 idle2 gclk",  32'(gclk_o),  32'd0);
    check("l1 edge count",  32'(gedge_o - base), 32'd1);
    // Reset in the only RUN cycle (gate would be enabled) cancels the edge.
    start_o = 1'b1;
    tick();
    start_o = 1'b0;
    rst_o   = 1'b1;
    check("l1 rst run busy", 32'(busy_o), 32'd1);
    tick();
    rst_o = 1'b0;
    check("l1 rst gclk",  32'(gclk_o),  32'd0);
    check("l1 rst synch", 32'(synch_o), 32'd0);
    check("l1 rst ready", 32'(rdy_o),   32'd1);
    check("l1 rst busy",  32'(busy_o),  32'd0);
    tick();
    check("l1 rst later synch", 32'(synch_o), 32'd0);
    check("l1 rst edge count",  32'(gedge_o - base), 32'd1);

    // AUTO_RESTART: rst high through cycle 0 -> Synch at 15, 29, 43.
    base = 0;
    for (int r = 0; r < 46; r++) begin
      tick();
      if (r == 0) base = gedge_a;
      check($sformatf("auto r%0d synch", r), 32'(synch_a),
            32'((r == 15) || (r == 29) || (r == 43)));
      check($sformatf("auto r%0d busy", r), 32'(busy_a),
            32'((r >= 2 && r <= 14) || (r >= 16 && r <= 28) ||
                (r >= 30 && r <= 42) || (r >= 44)));
      check($sformatf("auto r%0d ready", r), 32'(rdy_a), 32'd0);
      if (r == 1) rst_a = 1'b0;
    end
    check("auto edge count", 32'(gedge_a - base), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
